// File: rtl/processor_pkg.sv
// Shared definitions for the simple 16-bit processor.
//   WIDTH         : data path width
//   MV/MVI/ADD/SUB: opcode values found in IR[8:6]
//   step_t        : step counter encoding (T0..T3)
//   bus_sel_t     : which source drives the internal bus
package processor_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_REG  = 2'd1,
        SEL_DIN  = 2'd2,
        SEL_G    = 2'd3
    } bus_sel_t;

endpackage

// File: rtl/processor_regn.sv
// regn: WIDTH-bit register with load enable and asynchronous active-high clear.
//   clk  : clock
//   rst  : asynchronous clear, active high
//   load : capture d on the rising edge when high
//   d    : data in
//   q    : registered data out
module regn
    import processor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/processor.sv
// processor: multi-cycle 16-bit processor with eight general registers,
// one shared bus and an add/sub unit.
//   clk    : clock
//   Resetn : asynchronous reset, active high (asserted when 1)
//   DIN    : instruction word in T0, immediate data in mvi T1
//   Run    : start request, sampled in T0 only
//   Done   : high during the final step of an instruction
//   BUS    : internal bus value
//
// step | meaning
// T0   | idle / fetch: IR <- DIN when Run=1
// T1   | mv, mvi, nop complete; add/sub: A <- Rx
// T2   | add/sub: G <- A +/- Ry
// T3   | add/sub: Rx <- G, complete
module processor
    import processor_pkg::*;
(
    input  logic             clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] DIN,
    input  logic             Run,
    output logic             Done,
    output logic [WIDTH-1:0] BUS
);

    step_t            step, step_nxt;
    logic [8:0]       ir;
    logic             ir_load;
    bus_sel_t         sel;
    logic [2:0]       reg_idx;
    logic [7:0]       r_load;
    logic             a_load;
    logic             g_load;
    logic             done;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] r [0:7];

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    assign opcode = ir[8:6];
    assign rx     = ir[5:3];
    assign ry     = ir[2:0];

    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            step <= T0;
        end else begin
            step <= step_nxt;
        end
    end

    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= DIN[8:0];
        end
    end

    always_comb begin
        step_nxt = step;
        ir_load  = 1'b0;
        sel      = SEL_NONE;
        reg_idx  = 3'd0;
        r_load   = 8'd0;
        a_load   = 1'b0;
        g_load   = 1'b0;
        done     = 1'b0;
        unique case (step)
            T0: begin
                if (Run) begin
                    ir_load  = 1'b1;
                    step_nxt = T1;
                end
            end
            T1: begin
                case (opcode)
                    MV: begin
                        sel         = SEL_REG;
                        reg_idx     = ry;
                        r_load[rx]  = 1'b1;
                        done        = 1'b1;
                        step_nxt    = T0;
                    end
                    MVI: begin
                        sel         = SEL_DIN;
                        r_load[rx]  = 1'b1;
                        done        = 1'b1;
                        step_nxt    = T0;
                    end
                    ADD, SUB: begin
                        sel      = SEL_REG;
                        reg_idx  = rx;
                        a_load   = 1'b1;
                        step_nxt = T2;
                    end
                    default: begin
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                endcase
            end
            T2: begin
                sel      = SEL_REG;
                reg_idx  = ry;
                g_load   = 1'b1;
                step_nxt = T3;
            end
            T3: begin
                sel        = SEL_G;
                r_load[rx] = 1'b1;
                done       = 1'b1;
                step_nxt   = T0;
            end
            default: step_nxt = T0;
        endcase
    end

    always_comb begin
        bus = '0;
        unique case (sel)
            SEL_REG:  bus = r[reg_idx];
            SEL_DIN:  bus = DIN;
            SEL_G:    bus = g;
            default:  bus = '0;
        endcase
    end

    // Only add and sub ever reach T2, so the opcode alone picks the operation.
    assign alu = (opcode == SUB) ? (a - bus) : (a + bus);

    for (genvar i = 0; i < 8; i++) begin : g_regs
        regn u_r (
            .clk  (clk),
            .rst  (Resetn),
            .load (r_load[i]),
            .d    (bus),
            .q    (r[i])
        );
    end

    regn u_a (
        .clk  (clk),
        .rst  (Resetn),
        .load (a_load),
        .d    (bus),
        .q    (a)
    );

    regn u_g (
        .clk  (clk),
        .rst  (Resetn),
        .load (g_load),
        .d    (alu),
        .q    (g)
    );

    assign Done = done;
    assign BUS  = bus;

endmodule

// File: tb/tb_processor.sv
module tb_processor;
    import processor_pkg::*;

    logic        clk;
    logic        Resetn;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic [15:0] BUS;

    processor dut (
        .clk    (clk),
        .Resetn (Resetn),
        .DIN    (DIN),
        .Run    (Run),
        .Done   (Done),
        .BUS    (BUS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] bus;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] md [0:7];

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            assert (BUS === e.bus) else begin
                mismatched++;
                $error("FAIL %s BUS observed=%h expected=%h", e.tag, BUS, e.bus);
            end
            compared++;
            assert (Done === e.done) else begin
                mismatched++;
                $error("FAIL %s Done observed=%b expected=%b", e.tag, Done, e.done);
            end
        end
    end

    // Drive one cycle of stimulus and queue what the bus/Done must show in it.
    task automatic drive_step(input logic run, input logic [15:0] din,
                              input logic [15:0] ebus, input logic edone,
                              input string tag);
        exp_t e;
        Run  = run;
        DIN  = din;
        e.tag  = tag;
        e.bus  = ebus;
        e.done = edone;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive_step(1'b0, 16'($urandom), 16'h0000, 1'b0, "idle");
    endtask

    // Execute one instruction against the model; Run/DIN are scrambled after T0.
    task automatic exec(input logic [2:0] op, input logic [2:0] x,
                        input logic [2:0] y, input logic [15:0] imm);
        logic [15:0] iw;
        logic [15:0] res;
        string       t;
        iw = {7'($urandom), op, x, y};
        t  = $sformatf("op%0d R%0d,R%0d", op, x, y);
        drive_step(1'b1, iw, 16'h0000, 1'b0, {t, " T0"});
        case (op)
            MV: begin
                res = md[y];
                drive_step(1'($urandom), 16'($urandom), res, 1'b1, {t, " T1"});
                md[x] = res;
            end
            MVI: begin
                drive_step(1'($urandom), imm, imm, 1'b1, {t, " T1"});
                md[x] = imm;
            end
            ADD, SUB: begin
                res = (op == ADD) ? md[x] + md[y] : md[x] - md[y];
                drive_step(1'($urandom), 16'($urandom), md[x], 1'b0, {t, " T1"});
                drive_step(1'($urandom), 16'($urandom), md[y], 1'b0, {t, " T2"});
                drive_step(1'($urandom), 16'($urandom), res, 1'b1, {t, " T3"});
                md[x] = res;
            end
            default: begin
                drive_step(1'($urandom), 16'($urandom), 16'h0000, 1'b1, {t, " nop T1"});
            end
        endcase
    endtask

    // Copy Rx into R7 and require the bus to show a literal value.
    task automatic show(input logic [2:0] x, input logic [15:0] lit);
        drive_step(1'b1, {7'd0, MV, 3'd7, x}, 16'h0000, 1'b0, "show T0");
        drive_step(1'b0, 16'($urandom), lit, 1'b1, $sformatf("show R%0d", x));
        md[7] = lit;
    endtask

    initial begin
        Resetn = 1'b1;
        Run    = 1'b0;
        DIN    = 16'h0000;
        for (int i = 0; i < 8; i++) md[i] = 16'h0000;
        @(posedge clk);
        #1;
        drive_step(1'b1, 16'h0040, 16'h0000, 1'b0, "reset held");
        drive_step(1'b1, 16'h0081, 16'h0000, 1'b0, "reset held");
        Resetn = 1'b0;
        idle(2);
        show(3'd0, 16'h0000);
        show(3'd5, 16'h0000);

        exec(MVI, 3'd0, 3'd0, 16'hAAAA);
        show(3'd0, 16'hAAAA);
        exec(MV, 3'd1, 3'd0, 16'h0000);
        show(3'd1, 16'hAAAA);
        exec(MVI, 3'd0, 3'd0, 16'h5555);
        exec(ADD, 3'd0, 3'd1, 16'h0000);
        show(3'd0, 16'hFFFF);
        exec(SUB, 3'd0, 3'd1, 16'h0000);
        show(3'd0, 16'h5555);

        exec(MVI, 3'd0, 3'd0, 16'h0000);
        exec(MVI, 3'd1, 3'd0, 16'h0001);
        exec(SUB, 3'd0, 3'd1, 16'h0000);
        show(3'd0, 16'hFFFF);
        exec(MVI, 3'd1, 3'd0, 16'h8000);
        exec(ADD, 3'd1, 3'd1, 16'h0000);
        show(3'd1, 16'h0000);

        exec(MVI, 3'd2, 3'd0, 16'h1234);
        exec(SUB, 3'd2, 3'd2, 16'h0000);
        show(3'd2, 16'h0000);
        exec(MVI, 3'd3, 3'd0, 16'h0F0F);
        exec(MV, 3'd3, 3'd3, 16'h0000);
        show(3'd3, 16'h0F0F);
        exec(MVI, 3'd4, 3'd0, 16'h4321);
        exec(ADD, 3'd4, 3'd4, 16'h0000);
        show(3'd4, 16'h8642);

        for (int op = 4; op < 8; op++)
            exec(3'(op), 3'($urandom), 3'($urandom), 16'h0000);
        idle(2);

        for (int i = 0; i < 30; i++)
            exec(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 16'($urandom));

        exec(MVI, 3'd0, 3'd0, 16'h1111);
        exec(MVI, 3'd1, 3'd0, 16'h2222);
        drive_step(1'b1, {7'd0, ADD, 3'd0, 3'd1}, 16'h0000, 1'b0, "abort T0");
        drive_step(1'b0, 16'h0000, 16'h1111, 1'b0, "abort T1");
        Resetn = 1'b1;
        drive_step(1'b0, 16'h0000, 16'h0000, 1'b0, "abort T2 in reset");
        drive_step(1'b1, 16'h0040, 16'h0000, 1'b0, "abort reset held");
        Resetn = 1'b0;
        for (int i = 0; i < 8; i++) md[i] = 16'h0000;
        idle(3);
        show(3'd7, 16'h0000);
        for (int i = 0; i < 7; i++) show(3'(i), 16'h0000);
        exec(ADD, 3'd0, 3'd1, 16'h0000);
        show(3'd0, 16'h0000);

        compared++;
        assert (sb.size() === 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
